player_move_ctrl: RTL and testbench

Per-player controller that sequences the character movement datapath. It filters raw keypad directions into the mover's `num_input`, and runs the boots speed-boost timer. It also handles the death → respawn → invulnerability sequence and freezes the player on game over. It sits between the keypad/collision logic and `character_move`, and drives that block's direction, speed-select and position-reset controls.

---
 rtl/player_ctrl_pkg.sv | 29 ++
 rtl/frame_countdown.sv | 42 ++++
 rtl/player_move_ctrl.sv | 175 +++++++++++++++++
 tb/tb_player_move_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/player_ctrl_pkg.sv
// Shared types and helpers for the per-player movement controller.
// Holds the life-cycle state encoding and the keypad direction filter.
package player_ctrl_pkg;

   typedef enum logic [1:0] {
      ALIVE_ST,
      DYING_ST,
      INVULN_ST,
      FROZEN_ST
   } player_st_t;

   localparam int KEY_W     = 10;
   localparam int KEY_UP    = 8;
   localparam int KEY_DOWN  = 2;
   localparam int KEY_RIGHT = 6;
   localparam int KEY_LEFT  = 4;

   // Up beats down and right beats left, matching the mover's own priority.
   function automatic logic [KEY_W-1:0] filter_keys(input logic [KEY_W-1:0] keys);
      logic [KEY_W-1:0] f;
      f            = '0;
      f[KEY_UP]    = keys[KEY_UP];
      f[KEY_DOWN]  = keys[KEY_DOWN] & ~keys[KEY_UP];
      f[KEY_RIGHT] = keys[KEY_RIGHT];
      f[KEY_LEFT]  = keys[KEY_LEFT] & ~keys[KEY_RIGHT];
      return f;
   endfunction

endpackage

// File: rtl/frame_countdown.sv
// Loadable down-counter that decrements once per tick and saturates at zero.
// Priority: clear > load > tick; count is registered, zero is decoded from it.
module frame_countdown #(
   parameter int MAX = 300,
   parameter int W   = $clog2(MAX + 1)
) (
   input  logic         clk,
   input  logic         resetN,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         tick,
   input  logic         clear,
   output logic [W-1:0] count,
   output logic         zero
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (load) begin
         count_d = load_val;
      end else if (tick && (count_q != '0)) begin
         count_d = count_q - W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (resetN) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign zero  = (count_q == '0);

endmodule

// File: rtl/player_move_ctrl.sv
// Per-player sequencer: direction filter, boots speed boost, death/respawn/invulnerability, freeze.
// All outputs registered; num_input follows key_pressed by one cycle.
module player_move_ctrl #(
   parameter int BOOST_FRAMES   = 300,
   parameter int RESPAWN_FRAMES = 90,
   parameter int INVULN_FRAMES  = 120,
   parameter int BLINK_FRAMES   = 8
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       startOfFrame,
   input  logic [9:0] key_pressed,
   input  logic       boots_collision,
   input  logic       player_hit,
   input  logic       game_over,
   output logic [9:0] num_input,
   output logic       speed_fast,
   output logic       respawn,
   output logic       visible,
   output logic       invulnerable
);

   import player_ctrl_pkg::*;

   localparam int LIFE_MAX = (RESPAWN_FRAMES > INVULN_FRAMES) ? RESPAWN_FRAMES : INVULN_FRAMES;
   localparam int LIFE_W   = $clog2(LIFE_MAX + 1);
   localparam int BOOST_W  = $clog2(BOOST_FRAMES + 1);
   localparam int BLINK_W  = $clog2(BLINK_FRAMES + 1);

   player_st_t         state_q;
   player_st_t         state_d;
   logic               boots_q;
   logic               boots_edge;

   logic               life_load;
   logic [LIFE_W-1:0]  life_val;
   logic               life_clear;
   logic [LIFE_W-1:0]  life_count;
   logic               life_zero;
   logic               life_expire;

   logic               boost_clear;
   logic [BOOST_W-1:0] boost_count;
   logic               boost_zero;
   logic               boost_nz_d;

   logic [BLINK_W-1:0] blink_cnt_q;
   logic [BLINK_W-1:0] blink_cnt_d;
   logic               blink_q;
   logic               blink_d;

   logic [9:0]         num_input_q;
   logic               speed_fast_q;
   logic               respawn_q;
   logic               visible_q;
   logic               invulnerable_q;

   assign boots_edge  = boots_collision & ~boots_q;
   // Expiry is the tick that takes the count from 1 to 0, so the state moves right after it.
   assign life_expire = life_zero | (startOfFrame & (life_count == LIFE_W'(1)));

   always_comb begin
      state_d = state_q;
      if (game_over) begin
         state_d = FROZEN_ST;
      end else begin
         case (state_q)
            ALIVE_ST:  if (player_hit)  state_d = DYING_ST;
            DYING_ST:  if (life_expire) state_d = INVULN_ST;
            INVULN_ST: if (life_expire) state_d = ALIVE_ST;
            default:   state_d = FROZEN_ST;
         endcase
      end
   end

   always_comb begin
      life_load  = 1'b0;
      life_val   = LIFE_W'(RESPAWN_FRAMES);
      life_clear = (state_d == FROZEN_ST);
      if ((state_d == DYING_ST) && (state_q != DYING_ST)) begin
         life_load = 1'b1;
         life_val  = LIFE_W'(RESPAWN_FRAMES);
      end else if ((state_d == INVULN_ST) && (state_q == DYING_ST)) begin
         life_load = 1'b1;
         life_val  = LIFE_W'(INVULN_FRAMES);
      end
   end

   // Clearing from the next state keeps speed_fast low on the very first dying/frozen cycle.
   always_comb begin
      boost_clear = (state_d == DYING_ST) || (state_d == FROZEN_ST);
      if (boost_clear) begin
         boost_nz_d = 1'b0;
      end else if (boots_edge) begin
         boost_nz_d = 1'b1;
      end else begin
         boost_nz_d = ~(boost_zero | (startOfFrame & (boost_count == BOOST_W'(1))));
      end
   end

   always_comb begin
      blink_cnt_d = '0;
      blink_d     = 1'b1;
      if ((state_d == INVULN_ST) && (state_q == INVULN_ST)) begin
         blink_cnt_d = blink_cnt_q;
         blink_d     = blink_q;
         if (startOfFrame) begin
            if (blink_cnt_q == BLINK_W'(BLINK_FRAMES - 1)) begin
               blink_cnt_d = '0;
               blink_d     = ~blink_q;
            end else begin
               blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (resetN) begin
         state_q        <= ALIVE_ST;
         boots_q        <= 1'b0;
         blink_cnt_q    <= '0;
         blink_q        <= 1'b1;
         num_input_q    <= '0;
         speed_fast_q   <= 1'b0;
         respawn_q      <= 1'b0;
         visible_q      <= 1'b1;
         invulnerable_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         boots_q        <= boots_collision;
         blink_cnt_q    <= blink_cnt_d;
         blink_q        <= blink_d;
         num_input_q    <= ((state_d == ALIVE_ST) || (state_d == INVULN_ST)) ?
                           filter_keys(key_pressed) : '0;
         speed_fast_q   <= boost_nz_d;
         respawn_q      <= (state_q == DYING_ST) && (state_d == INVULN_ST);
         invulnerable_q <= (state_d == INVULN_ST);
         case (state_d)
            DYING_ST:  visible_q <= 1'b0;
            INVULN_ST: visible_q <= blink_d;
            default:   visible_q <= 1'b1;
         endcase
      end
   end

   frame_countdown #(.MAX(LIFE_MAX)) u_life_cnt (
      .clk      (clk),
      .resetN   (resetN),
      .load     (life_load),
      .load_val (life_val),
      .tick     (startOfFrame),
      .clear    (life_clear),
      .count    (life_count),
      .zero     (life_zero)
   );

   frame_countdown #(.MAX(BOOST_FRAMES)) u_boost_cnt (
      .clk      (clk),
      .resetN   (resetN),
      .load     (boots_edge),
      .load_val (BOOST_W'(BOOST_FRAMES)),
      .tick     (startOfFrame),
      .clear    (boost_clear),
      .count    (boost_count),
      .zero     (boost_zero)
   );

   assign num_input    = num_input_q;
   assign speed_fast   = speed_fast_q;
   assign respawn      = respawn_q;
   assign visible      = visible_q;
   assign invulnerable = invulnerable_q;

endmodule

// File: tb/tb_player_move_ctrl.sv
// Scoreboard bench for player_move_ctrl with short frame parameters.
// Each step pushes the outputs expected after the next clock edge; a monitor pops and compares them.
module tb_player_move_ctrl;

   logic       clk = 1'b0;
   logic       resetN;
   logic       startOfFrame;
   logic [9:0] key_pressed;
   logic       boots_collision;
   logic       player_hit;
   logic       game_over;
   logic [9:0] num_input;
   logic       speed_fast;
   logic       respawn;
   logic       visible;
   logic       invulnerable;

   typedef struct {
      int    at;
      string tag;
      int    sel;
      int    val;
   } exp_t;

   exp_t sb[$];
   int   cyc_n  = 0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   player_move_ctrl #(
      .BOOST_FRAMES   (4),
      .RESPAWN_FRAMES (3),
      .INVULN_FRAMES  (6),
      .BLINK_FRAMES   (2)
   ) dut (
      .clk             (clk),
      .resetN          (resetN),
      .startOfFrame    (startOfFrame),
      .key_pressed     (key_pressed),
      .boots_collision (boots_collision),
      .player_hit      (player_hit),
      .game_over       (game_over),
      .num_input       (num_input),
      .speed_fast      (speed_fast),
      .respawn         (respawn),
      .visible         (visible),
      .invulnerable    (invulnerable)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc_n);
      end
   endtask

   function automatic logic [31:0] dut_out(input int sel);
      case (sel)
         0:       return 32'(num_input);
         1:       return 32'(speed_fast);
         2:       return 32'(respawn);
         3:       return 32'(visible);
         default: return 32'(invulnerable);
      endcase
   endfunction

   function automatic string sel_name(input int sel);
      case (sel)
         0:       return ".num";
         1:       return ".fast";
         2:       return ".resp";
         3:       return ".vis";
         default: return ".inv";
      endcase
   endfunction

   always @(posedge clk) begin
      cyc_n = cyc_n + 1;
      #1;
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].at == cyc_n) begin
            check_val(sb[i].tag, dut_out(sb[i].sel), sb[i].val);
            sb.delete(i);
         end
      end
   end

   task automatic push(input string tag, input int sel, input int val);
      exp_t e;
      e.at  = cyc_n + 1;
      e.tag = {tag, sel_name(sel)};
      e.sel = sel;
      e.val = val;
      sb.push_back(e);
   endtask

   task automatic step(input string tag, input logic rst, input logic [9:0] key,
                       input logic boots, input logic hit, input logic go, input logic sof,
                       input int e_num, input int e_fast, input int e_resp,
                       input int e_vis, input int e_inv);
      resetN          = rst;
      key_pressed     = key;
      boots_collision = boots;
      player_hit      = hit;
      game_over       = go;
      startOfFrame    = sof;
      push(tag, 0, e_num);
      push(tag, 1, e_fast);
      push(tag, 2, e_resp);
      push(tag, 3, e_vis);
      push(tag, 4, e_inv);
      @(posedge clk);
      #2;
   endtask

   initial begin
      // reset values, including with every other input active
      step("rst",   1, 10'h000, 0, 0, 0, 0,  0, 0, 0, 1, 0);
      step("rst2",  1, 10'h3FF, 0, 1, 1, 1,  0, 0, 0, 1, 0);

      // direction filter
      step("flt_udr", 0, 10'h144, 0, 0, 0, 0,  'h140, 0, 0, 1, 0);
      step("flt_b5",  0, 10'h020, 0, 0, 0, 0,  'h000, 0, 0, 1, 0);
      step("flt_all", 0, 10'h3FF, 0, 0, 0, 0,  'h140, 0, 0, 1, 0);
      step("flt_dl",  0, 10'h014, 0, 0, 0, 0,  'h014, 0, 0, 1, 0);
      step("flt_ul",  0, 10'h110, 0, 0, 0, 0,  'h110, 0, 0, 1, 0);
      step("flt_dr",  0, 10'h044, 0, 0, 0, 0,  'h044, 0, 0, 1, 0);

      // single boost lasts 4 frames
      step("bst_ld", 0, 10'h000, 1, 0, 0, 0,  0, 1, 0, 1, 0);
      for (int f = 1; f <= 4; f++) begin
         step($sformatf("bst_f%0d", f), 0, 10'h000, 0, 0, 0, 1,  0, (f < 4), 0, 1, 0);
         step($sformatf("bst_g%0d", f), 0, 10'h000, 0, 0, 0, 0,  0, (f < 4), 0, 1, 0);
      end

      // re-pulse after 2 frames reloads: 6 frames in total
      step("bst_a", 0, 10'h000, 1, 0, 0, 0,  0, 1, 0, 1, 0);
      for (int f = 1; f <= 2; f++) begin
         step($sformatf("bst_r%0d", f), 0, 10'h000, 0, 0, 0, 1,  0, 1, 0, 1, 0);
         step($sformatf("bst_rg%0d", f), 0, 10'h000, 0, 0, 0, 0,  0, 1, 0, 1, 0);
      end
      step("bst_re", 0, 10'h000, 1, 0, 0, 0,  0, 1, 0, 1, 0);
      for (int f = 3; f <= 6; f++) begin
         step($sformatf("bst_r%0d", f), 0, 10'h000, 0, 0, 0, 1,  0, (f < 6), 0, 1, 0);
         step($sformatf("bst_rg%0d", f), 0, 10'h000, 0, 0, 0, 0,  0, (f < 6), 0, 1, 0);
      end

      // edge in the same cycle as a frame tick: load wins over decrement
      step("bst_ls", 0, 10'h000, 1, 0, 0, 1,  0, 1, 0, 1, 0);
      for (int f = 1; f <= 4; f++) begin
         step($sformatf("bst_s%0d", f), 0, 10'h000, 0, 0, 0, 1,  0, (f < 4), 0, 1, 0);
      end

      // death with boost active: hidden, no motion, boost cleared
      step("dth_bst", 0, 10'h144, 1, 0, 0, 0,  'h140, 1, 0, 1, 0);
      step("dth_hit", 0, 10'h144, 0, 1, 0, 0,  0, 0, 0, 0, 0);
      for (int f = 1; f <= 2; f++) begin
         step($sformatf("dth_f%0d", f), 0, 10'h144, 0, 0, 0, 1,  0, 0, 0, 0, 0);
         step($sformatf("dth_g%0d", f), 0, 10'h144, 0, 0, 0, 0,  0, 0, 0, 0, 0);
      end
      step("dth_exp", 0, 10'h144, 0, 0, 0, 1,  'h140, 0, 1, 1, 1);

      // invulnerability: hits ignored, blink 1,1,0,0,1,1, boost usable
      step("inv_hit", 0, 10'h144, 0, 1, 0, 0,  'h140, 0, 0, 1, 1);
      step("inv_t1",  0, 10'h144, 0, 0, 0, 1,  'h140, 0, 0, 1, 1);
      step("inv_t2",  0, 10'h144, 0, 0, 0, 1,  'h140, 0, 0, 0, 1);
      step("inv_t3",  0, 10'h144, 0, 0, 0, 1,  'h140, 0, 0, 0, 1);
      step("inv_bst", 0, 10'h144, 1, 0, 0, 0,  'h140, 1, 0, 0, 1);
      step("inv_t4",  0, 10'h144, 0, 0, 0, 1,  'h140, 1, 0, 1, 1);
      step("inv_t5",  0, 10'h144, 0, 0, 0, 1,  'h140, 1, 0, 1, 1);
      step("inv_t6",  0, 10'h144, 0, 1, 0, 1,  'h140, 1, 0, 1, 0);
      step("alv_chk", 0, 10'h144, 0, 0, 0, 0,  'h140, 1, 0, 1, 0);

      // game over together with a hit freezes the player for good
      step("frz_go", 0, 10'h144, 0, 1, 1, 0,  0, 0, 0, 1, 0);
      for (int i = 0; i < 4; i++) begin
         step($sformatf("frz_h%0d", i), 0, 10'h144, i[0], 1, 0, 1,  0, 0, 0, 1, 0);
      end

      // reset in the middle of dying: back to reset values, no respawn afterwards
      step("rst_a",  1, 10'h000, 0, 0, 0, 0,  0, 0, 0, 1, 0);
      step("r_hit",  0, 10'h000, 0, 1, 0, 0,  0, 0, 0, 0, 0);
      step("r_f1",   0, 10'h000, 0, 0, 0, 1,  0, 0, 0, 0, 0);
      step("r_mid",  1, 10'h000, 0, 0, 0, 1,  0, 0, 0, 1, 0);
      for (int f = 1; f <= 5; f++) begin
         step($sformatf("r_post%0d", f), 0, 10'h000, 0, 0, 0, 1,  0, 0, 0, 1, 0);
         step($sformatf("r_gap%0d", f), 0, 10'h000, 0, 0, 0, 0,  0, 0, 0, 1, 0);
      end

      check_val("sb_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
